// File: rtl/etcpu_pipe_pkg.sv
// Shared constants and types for the etcpu pipeline control slice.
package etcpu_pipe_pkg;

    localparam int unsigned STG_IF = 0;
    localparam int unsigned STG_ID = 1;
    localparam int unsigned STG_EX = 2;
    localparam int unsigned STG_MA = 3;
    localparam int unsigned STG_WB = 4;

    localparam int unsigned PC_INC     = 4;
    localparam int unsigned ETCPU_PC_W = 32;

    typedef logic [ETCPU_PC_W-1:0] pc_t;

endpackage

// File: rtl/etcpu_flush_arb.sv
// Highest-index priority encoder over accepted flush requests; the oldest
// instruction wins and its redirect target is selected.
module etcpu_flush_arb #(
    parameter int unsigned N_STAGES = 5,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned IDX_W    = $clog2(N_STAGES)
) (
    input  logic [N_STAGES-1:0]      req,
    input  logic [N_STAGES*PC_W-1:0] flush_pc,
    output logic                     found,
    output logic [IDX_W-1:0]         idx,
    output logic [PC_W-1:0]          sel_pc
);

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        sel_pc = '0;
        // Ascending scan: the last hit (highest index) overwrites earlier ones.
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            if (req[i]) begin
                found  = 1'b1;
                idx    = IDX_W'(i);
                sel_pc = flush_pc[i*PC_W +: PC_W];
            end
        end
    end

endmodule

// File: rtl/etcpu_pipe_ctrl.sv
// Pipeline control: PC register, per-stage valid bits, load enables and bubbles.
// Optional performance counters under `ETCPU_PIPE_PERF_EN.
module etcpu_pipe_ctrl
    import etcpu_pipe_pkg::*;
#(
    parameter int unsigned     N_STAGES       = 5,
    parameter int unsigned     PC_W           = 32,
    parameter int unsigned     INST_MEM_DEPTH = 256,
    parameter logic [PC_W-1:0] RESET_PC       = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_rdy,
    input  logic [N_STAGES-1:0]      stall_req,
    input  logic [N_STAGES-1:0]      flush_req,
    input  logic [N_STAGES*PC_W-1:0] flush_pc,
    output logic [PC_W-1:0]          pc,
    output logic [N_STAGES-1:0]      stg_vld,
    output logic [N_STAGES-1:0]      stg_en,
    output logic [N_STAGES-1:0]      stg_bubble
`ifdef ETCPU_PIPE_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_flush_cnt
`endif
);

    localparam int unsigned     IDX_W  = $clog2(N_STAGES);
    localparam logic [PC_W-1:0] PC_MOD = PC_W'(INST_MEM_DEPTH * 4);

    logic [N_STAGES-1:1] vld_r;
    logic [N_STAGES-1:0] occ;
    logic [N_STAGES-1:0] hold;
    logic [N_STAGES-1:0] acc;
    logic [N_STAGES-2:0] adv;
    logic [N_STAGES-2:0] kill_src;
    logic                kill;
    logic [IDX_W-1:0]    win_idx;
    logic [PC_W-1:0]     tgt_raw;
    logic [PC_W-1:0]     pc_nxt;

    // IF occupancy uses raw fetch_rdy, not stg_vld[0]: stg_vld[0] depends on
    // kill, which depends on hold, so the gated value would form a comb loop.
    always_comb begin
        occ                = {vld_r, fetch_rdy};
        hold               = '0;
        hold[N_STAGES-1]   = occ[N_STAGES-1] & stall_req[N_STAGES-1];
        for (int unsigned i = N_STAGES - 1; i > 0; i--) begin
            hold[i-1] = occ[i-1] & (stall_req[i-1] | hold[i]);
        end
        acc = flush_req & occ & ~hold;
    end

    etcpu_flush_arb #(
        .N_STAGES (N_STAGES),
        .PC_W     (PC_W),
        .IDX_W    (IDX_W)
    ) u_flush_arb (
        .req      (acc),
        .flush_pc (flush_pc),
        .found    (kill),
        .idx      (win_idx),
        .sel_pc   (tgt_raw)
    );

    always_comb begin
        adv        = occ[N_STAGES-2:0] & ~hold[N_STAGES-2:0];
        kill_src   = '0;
        stg_en     = '0;
        stg_bubble = '0;
        for (int unsigned j = 0; j < N_STAGES - 1; j++) begin
            kill_src[j] = kill & (IDX_W'(j) < win_idx);
        end
        stg_en[STG_IF] = kill | (fetch_rdy & ~hold[STG_IF]);
        // A killed source forces the load so the bubble overrides any hold.
        for (int unsigned i = 1; i < N_STAGES; i++) begin
            stg_en[i]     = kill_src[i-1] | ~hold[i];
            stg_bubble[i] = kill_src[i-1] | (~hold[i] & ~adv[i-1]);
        end
        stg_vld = {vld_r, fetch_rdy & ~kill};
        pc_nxt  = kill ? ((tgt_raw % PC_MOD) & {{(PC_W-2){1'b1}}, 2'b00})
                       : ((pc + PC_W'(PC_INC)) % PC_MOD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            vld_r <= '0;
        end else begin
            if (stg_en[STG_IF]) pc <= pc_nxt;
            for (int unsigned i = 1; i < N_STAGES; i++) begin
                if (stg_en[i]) vld_r[i] <= ~kill_src[i-1] & adv[i-1];
            end
        end
    end

`ifdef ETCPU_PIPE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (hold[STG_IF] && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (kill && perf_flush_cnt != '1)         perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_etcpu_pipe_ctrl.sv
// Randomized bench for etcpu_pipe_ctrl with an in-bench behavioural model,
// plus directed sequences pinning the model to hand-computed values.
module tb_etcpu_pipe_ctrl;
    import etcpu_pipe_pkg::*;

    localparam int N   = 5;
    localparam int PW  = 32;
    localparam int MOD = 256 * 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_rdy;
    logic [N-1:0]  stall_req;
    logic [N-1:0]  flush_req;
    logic [N*PW-1:0] flush_pc;
    logic [PW-1:0] pc;
    logic [N-1:0]  stg_vld;
    logic [N-1:0]  stg_en;
    logic [N-1:0]  stg_bubble;
`ifdef ETCPU_PIPE_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_flush_cnt;
    longint        m_stall_cnt, m_flush_cnt;
`endif

    etcpu_pipe_ctrl #(
        .N_STAGES       (N),
        .PC_W           (PW),
        .INST_MEM_DEPTH (256),
        .RESET_PC       (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_rdy  (fetch_rdy),
        .stall_req  (stall_req),
        .flush_req  (flush_req),
        .flush_pc   (flush_pc),
        .pc         (pc),
        .stg_vld    (stg_vld),
        .stg_en     (stg_en),
        .stg_bubble (stg_bubble)
`ifdef ETCPU_PIPE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    pc_t  m_pc, n_pc;
    bit [N-1:0] m_v, n_v;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_v  = '0;
`ifdef ETCPU_PIPE_PERF_EN
        m_stall_cnt = 0;
        m_flush_cnt = 0;
`endif
    endtask

    // Apply inputs, let them settle, compare against the model, prepare next state.
    task automatic drive(input logic fr, input logic [N-1:0] st, input logic [N-1:0] fl,
                         input logic [N*PW-1:0] fp);
        bit [N-1:0] occ, blk, e_vld, e_en, e_bub;
        int         win;
        bit         mv;
        fetch_rdy = fr; stall_req = st; flush_req = fl; flush_pc = fp;
        #1;
        occ = m_v; occ[0] = fr;
        blk = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (occ[i] && st[i]) blk[i] = 1'b1;
            if (i < N - 1) begin
                if (occ[i] && blk[i+1]) blk[i] = 1'b1;
            end
        end
        win = -1;
        for (int k = 0; k < N; k++) if (fl[k] && occ[k] && !blk[k]) win = k;
        e_vld = m_v; e_vld[0] = fr && (win < 0);
        e_en = '0; e_bub = '0; n_v = m_v;
        e_en[0] = (win >= 0) || (fr && !blk[0]);
        for (int i = 1; i < N; i++) begin
            if (win >= i) begin
                e_en[i] = 1'b1; e_bub[i] = 1'b1; n_v[i] = 1'b0;
            end else begin
                e_en[i]  = !blk[i];
                mv       = occ[i-1] && !blk[i-1];
                e_bub[i] = e_en[i] && !mv;
                if (e_en[i]) n_v[i] = mv;
            end
        end
        if (win >= 0)      n_pc = pc_t'((fp[win*PW +: PW] % MOD) & ~32'h3);
        else if (e_en[0])  n_pc = pc_t'((m_pc + 4) % MOD);
        else               n_pc = m_pc;
        check("pc", 64'(pc), 64'(m_pc));
        check("stg_vld", 64'(stg_vld), 64'(e_vld));
        check("stg_en", 64'(stg_en), 64'(e_en));
        check("stg_bubble", 64'(stg_bubble), 64'(e_bub));
`ifdef ETCPU_PIPE_PERF_EN
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall_cnt));
        check("perf_flush_cnt", 64'(perf_flush_cnt), 64'(m_flush_cnt));
        if (blk[0])   m_stall_cnt++;
        if (win >= 0) m_flush_cnt++;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_pc = n_pc;
        m_v  = n_v;
    endtask

    task automatic mid_reset();
        fetch_rdy = 1'b0; stall_req = '0; flush_req = '0; flush_pc = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_vld", 64'(stg_vld), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    logic [N*PW-1:0] fp;
    logic [N-1:0]    st, fl;

    initial begin
        rst = 1'b1; fetch_rdy = 1'b0; stall_req = '0; flush_req = '0; flush_pc = '0;
        #1;
        check("init_pc", 64'(pc), 64'h0);
        check("init_vld", 64'(stg_vld), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Free run then mid-cycle reset, then pipeline fill from reset.
        for (int c = 0; c < 3; c++) begin drive(1'b1, '0, '0, '0); tick(); end
        mid_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, '0, '0, '0);
            check("fill_vld", 64'(stg_vld), 64'((1 << (c + 1)) - 1));
            check("fill_pc", 64'(pc), 64'(4 * c));
            tick();
        end

        // MA stall for two cycles.
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 5'b01000, '0, '0);
            check("stall_en", 64'(stg_en), 64'h10);
            check("stall_bub", 64'(stg_bubble), 64'h10);
            tick();
            check("stall_pc", 64'(pc), 64'h14);
        end
        drive(1'b1, '0, '0, '0);
        check("resume_en", 64'(stg_en), 64'h1f);
        tick();
        check("resume_pc", 64'(pc), 64'h18);

        // EX flush.
        fp = '0; fp[2*PW +: PW] = 32'h42;
        drive(1'b1, '0, 5'b00100, fp);
        tick();
        check("exfl_pc", 64'(pc), 64'h40);
        check("exfl_vld", 64'(stg_vld[3:1]), 64'b100);

        // Simultaneous flushes at ID and MA: MA (older) wins.
        for (int c = 0; c < 3; c++) begin drive(1'b1, '0, '0, '0); tick(); end
        fp = '0; fp[1*PW +: PW] = 32'h80; fp[3*PW +: PW] = 32'h20;
        drive(1'b1, '0, 5'b01010, fp);
        tick();
        check("dual_pc", 64'(pc), 64'h20);
        check("dual_vld", 64'(stg_vld[4:1]), 64'b1000);

        // Flush from an invalid stage is ignored.
        fp = '0; fp[2*PW +: PW] = 32'h200;
        drive(1'b1, '0, 5'b00100, fp);
        tick();
        check("inv_fl_pc", 64'(pc), 64'h24);

        // Flush from a held stage waits until the stall drops.
        for (int c = 0; c < 4; c++) begin drive(1'b1, '0, '0, '0); tick(); end
        fp = '0; fp[3*PW +: PW] = 32'h100;
        drive(1'b1, 5'b01000, 5'b01000, fp);
        check("held_fl_en", 64'(stg_en), 64'h10);
        tick();
        check("held_fl_pc", 64'(pc), 64'h34);
        drive(1'b1, '0, 5'b01000, fp);
        tick();
        check("rel_fl_pc", 64'(pc), 64'h100);

        // Wrap at INST_MEM_DEPTH*4 and fetch_rdy=0 hold.
        fp = '0; fp[4*PW +: PW] = 32'hFFFF_F3FE;
        drive(1'b1, '0, 5'b10000, fp);
        tick();
        check("wrap_tgt_pc", 64'(pc), 64'h3FC);
        drive(1'b1, '0, '0, '0);
        tick();
        check("wrap_pc", 64'(pc), 64'h0);
        drive(1'b0, '0, '0, '0);
        check("nofetch_vld0", 64'(stg_vld[0]), 64'h0);
        check("nofetch_en0", 64'(stg_en[0]), 64'h0);
        tick();
        check("nofetch_pc", 64'(pc), 64'h0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) mid_reset();
            st = '0; fl = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) st[i] = 1'b1;
                if (i > 0 && $urandom_range(0, 19) == 0) fl[i] = 1'b1;
            end
            for (int i = 0; i < N; i++) fp[i*PW +: PW] = $urandom;
            drive($urandom_range(0, 4) != 0, st, fl, fp);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
